// File: rtl/seq_detector_param.sv
// Serial pattern detector with a programmable pattern, overlap/non-overlap
// modes, a history fill level and a saturating match counter.
module seq_detector_param #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         seq_in,
    input  logic                         in_valid,
    input  logic [SEQ_LEN-1:0]           cfg_pattern,
    input  logic                         cfg_load,
    input  logic                         cfg_overlap,
    input  logic                         count_clr,
    output logic                         seq_detected,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0] fill_level
);
    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    logic [SEQ_LEN-1:0] hist_q, hist_d;
    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic               pat_vld_q, pat_vld_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d;

    logic               accept;
    logic [SEQ_LEN-1:0] cand;
    logic               full;
    logic               match;

    // A load wins over data on the same edge, so the bit is simply dropped.
    // pat_vld_q keeps the all-zero reset pattern from matching a zero stream
    // before any pattern has been loaded.
    always_comb begin
        accept = in_valid && !cfg_load;
        cand   = {hist_q[SEQ_LEN-2:0], seq_in};
        full   = (fill_q >= FILL_W'(SEQ_LEN - 1));
        match  = accept && pat_vld_q && full && (cand == pat_q);
    end

    // Next-state for history, pattern, fill level, counter and pulse.
    always_comb begin
        hist_d    = hist_q;
        pat_d     = pat_q;
        pat_vld_d = pat_vld_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        det_d     = match;

        if (accept)
            hist_d = cand;

        if (cfg_load) begin
            pat_d     = cfg_pattern;
            pat_vld_d = 1'b1;
            fill_d    = '0;
        end else if (accept) begin
            // Non-overlap restarts the fill so the matched bits cannot be reused;
            // history itself still shifts, the fill level alone gates matching.
            if (match && !cfg_overlap)
                fill_d = '0;
            else if (fill_q != FILL_W'(SEQ_LEN))
                fill_d = fill_q + FILL_W'(1);
        end

        if (count_clr)
            cnt_d = '0;
        else if (match && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= '0;
            pat_q     <= '0;
            pat_vld_q <= 1'b0;
            fill_q    <= '0;
            cnt_q     <= '0;
            det_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            pat_vld_q <= pat_vld_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
        end
    end

    assign seq_detected = det_q;
    assign match_count  = cnt_q;
    assign fill_level   = fill_q;

endmodule
